ex_mem_wb_pipe: RTL and testbench
=================================

// Module: ex_mem_wb_pipe
// PURPOSE
//  EX/MEM and MEM/WB pipeline registers plus the data-memory access stage of the 5-stage core.
//  Registers EX results, issues loads/stores to the data memory and stalls on wait states.
//  Produces the ex_mem_*/mem_wb_* destination and value signals consumed by the EX-stage forwarding unit.
// PARAMETERS
//  TIMEOUT_CYCLES  200  wait cycles before a stuck access is aborted (DMEM_TIMEOUT_EN only)
//  TIMEOUT_W       8    width of the wait counter; must satisfy 2**TIMEOUT_W > TIMEOUT_CYCLES
// PORTS
//  clk               in   1   clock, rising edge
//  rst_n             in   1   asynchronous, active-low reset
//  ex_valid          in   1   EX holds a real instruction (0 = bubble)
//  ex_reg_write      in   1   instruction writes rd
//  ex_mem_read       in   1   load
//  ex_mem_write      in   1   store
//  ex_funct3         in   3   LB/LH/LW/LBU/LHU, SB/SH/SW encoding
//  ex_rd             in   5   destination register
//  ex_alu_result     in   32  ALU result / effective address
//  ex_store_data     in   32  rs2 value (already forwarded)
//  dmem_req          out  1   access request
//  dmem_we           out  1   1 = store
//  dmem_addr         out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_be           out  4   byte-lane enables
//  dmem_wdata        out  32  lane-replicated store data
//  dmem_rdata        in   32  load data, valid when dmem_ready
//  dmem_ready        in   1   access complete this cycle
//  mem_stall         out  1   freeze PC, IF/ID, ID/EX (combinational)
//  misalign          out  1   1-cycle pulse: misaligned access suppressed
//  ex_mem_reg_write  out  1   EX/MEM valid & reg_write
//  ex_mem_rd         out  5   EX/MEM rd
//  ex_mem_alu_result out  32  EX/MEM forward value
//  mem_wb_reg_write  out  1   MEM/WB valid & reg_write
//  mem_wb_rd         out  5   MEM/WB rd
//  mem_wb_wdata      out  32  write-back value (load data or ALU result)
// BEHAVIOUR
//  - Reset: every register and output is 0; FSM = S_RUN. Reset mid-access drops the access; dmem_req falls immediately.
//  - EX/MEM loads the EX inputs on each edge unless mem_stall=1. ex_valid=0 loads a bubble (valid=0, reg_write=0).
//  - dmem_req = EX/MEM valid & (mem_read|mem_write) & aligned. Address, be, wdata and we come from EX/MEM only.
//  - Lanes: byte -> be=1<<a[1:0]; half -> 0011/1100 by a[1]; word -> 1111.
//    wdata replicates the byte/half across all lanes.
//  - Misaligned: half with a[0]=1, or word with a[1:0]!=0.
//    No dmem_req; store dropped; load writes 0; misalign pulses 1 cycle; no stall.
//  - Load extract: select lane by a[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
//  - FSM S_RUN: request & !dmem_ready -> mem_stall=1, go S_WAIT; request & dmem_ready -> complete, 0 stall cycles.
//  - FSM S_WAIT: dmem_req=1 with stable addr/be/wdata/we; mem_stall=1 until dmem_ready.
//    On dmem_ready: mem_stall=0 that cycle, complete, return to S_RUN.
//  - During a stall, EX/MEM and MEM/WB both hold. The repeated RF write is idempotent and keeps
//    MEM/WB forwarding valid for the frozen EX instruction.
//  - MEM/WB loads on the completing edge: wdata = extracted load data if mem_read, else alu_result.
//    Latency EX->WB is 2 cycles plus wait cycles.
//  - Back-to-back loads/stores: the next request is issued the cycle after completion.
//  - dmem_ready while no request is ignored.
// CONFIGURATION
//  DMEM_TIMEOUT_EN defined:
//    - TIMEOUT_W counter clears on S_RUN and increments each S_WAIT cycle.
//    - At TIMEOUT_CYCLES it forces completion: a load writes 32'h0, a store is abandoned,
//      extra output dmem_fault pulses 1 cycle, and the FSM returns to S_RUN.
//  Not defined: no counter and no dmem_fault port; S_WAIT waits indefinitely.
// TESTING
//  1. LW x5 at 0x100, dmem_ready same cycle, rdata=0xDEADBEEF
//     -> no stall; mem_wb_rd=5, wdata=0xDEADBEEF 2 cycles after EX.
//  2. LB at 0x103, rdata=0x80xxxxxx -> wdata=0xFFFFFF80; same access as LBU -> 0x00000080.
//  3. SH x6=0x1234 at 0x102 -> dmem_be=1100, wdata=0x12341234, we=1; mem_wb_reg_write=0.
//  4. LW, dmem_ready held low 3 cycles -> mem_stall high 3 cycles, addr stable, EX/MEM and MEM/WB frozen;
//     completes on the 4th cycle.
//  5. LW at 0x101 -> dmem_req never high, misalign pulse, wdata=0; SW at 0x102 -> no write.
//  6. rst_n low during S_WAIT -> dmem_req=0 and all outputs 0 at once; with DMEM_TIMEOUT_EN,
//     ready never asserted -> dmem_fault after 200 wait cycles.

Source files
------------

// File: rtl/ex_mem_wb_pipe_if.sv
// ex_mem_wb_pipe_if: data-memory request/response bus between the MEM stage and the data memory.
interface ex_mem_wb_pipe_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  modport master(output req, we, addr, be, wdata, input rdata, ready);
  modport slave(input req, we, addr, be, wdata, output rdata, ready);
endinterface

// File: rtl/ex_mem_wb_pipe.sv
// ex_mem_wb_pipe: EX/MEM and MEM/WB registers with the data-memory access stage and wait-state stall.
// Optional DMEM_TIMEOUT_EN aborts an access stuck in S_WAIT and adds the o_dmem_fault pulse.
module ex_mem_wb_pipe #(
  parameter int TIMEOUT_CYCLES = 200,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ex_valid,
  input  logic        i_ex_reg_write,
  input  logic        i_ex_mem_read,
  input  logic        i_ex_mem_write,
  input  logic [2:0]  i_ex_funct3,
  input  logic [4:0]  i_ex_rd,
  input  logic [31:0] i_ex_alu_result,
  input  logic [31:0] i_ex_store_data,
  ex_mem_wb_pipe_if.master dmem,
  output logic        o_mem_stall,
  output logic        o_misalign,
`ifdef DMEM_TIMEOUT_EN
  output logic        o_dmem_fault,
`endif
  output logic        o_ex_mem_reg_write,
  output logic [4:0]  o_ex_mem_rd,
  output logic [31:0] o_ex_mem_alu_result,
  output logic        o_mem_wb_reg_write,
  output logic [4:0]  o_mem_wb_rd,
  output logic [31:0] o_mem_wb_wdata
);
  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  if (2 ** TIMEOUT_W <= TIMEOUT_CYCLES) begin : g_bad_timeout_w
    $error("TIMEOUT_W too narrow for TIMEOUT_CYCLES");
  end
  logic [0:0]  r_state;
  logic        r_rw, r_mr, r_mw;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic [31:0] r_alu, r_sd;
  logic        r_wb_rw;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic [1:0]  w_a, w_size;
  logic        w_mis, w_access, w_req, w_to, w_done, w_sx;
  logic [3:0]  w_be;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld, w_wb;
  assign w_a      = r_alu[1:0];
  assign w_size   = r_f3[1:0];
  assign w_access = r_mr | r_mw;
  assign w_mis    = w_access & ((w_size == 2'b01 & w_a[0]) | (w_size == 2'b10 & w_a != 2'b00));
  assign w_req    = w_access & ~w_mis;
  assign w_done   = w_req & (dmem.ready | w_to);
`ifdef DMEM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_cnt;
  assign w_to         = r_state == S_WAIT && r_cnt == TIMEOUT_W'(TIMEOUT_CYCLES) && !dmem.ready;
  assign o_dmem_fault = w_to;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= r_state == S_WAIT ? r_cnt + 1'b1 : '0;
`else
  assign w_to = 1'b0;
`endif
  assign w_be   = w_size == 2'b00 ? 4'b0001 << w_a : w_size == 2'b01 ? (w_a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_byte = dmem.rdata[{w_a, 3'b000} +: 8];
  assign w_half = w_a[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
  assign w_sx   = ~r_f3[2];
  assign w_ld   = w_size == 2'b00 ? {{24{w_sx & w_byte[7]}}, w_byte} :
                  w_size == 2'b01 ? {{16{w_sx & w_half[15]}}, w_half} : dmem.rdata;
  // misaligned and timed-out loads write zero rather than stale bus data
  assign w_wb   = r_mr ? ((w_mis | w_to) ? 32'h0 : w_ld) : r_alu;
  assign dmem.req   = w_req;
  assign dmem.we    = w_req & r_mw;
  assign dmem.addr  = {r_alu[31:2], 2'b00};
  assign dmem.be    = w_req ? w_be : 4'b0000;
  assign dmem.wdata = w_size == 2'b00 ? {4{r_sd[7:0]}} : w_size == 2'b01 ? {2{r_sd[15:0]}} : r_sd;
  assign o_mem_stall         = w_req & ~w_done;
  assign o_misalign          = w_mis;
  assign o_ex_mem_reg_write  = r_rw;
  assign o_ex_mem_rd         = r_rd;
  assign o_ex_mem_alu_result = r_alu;
  assign o_mem_wb_reg_write  = r_wb_rw;
  assign o_mem_wb_rd         = r_wb_rd;
  assign o_mem_wb_wdata      = r_wb_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= S_RUN;
      r_rw      <= 1'b0;
      r_mr      <= 1'b0;
      r_mw      <= 1'b0;
      r_f3      <= '0;
      r_rd      <= '0;
      r_alu     <= '0;
      r_sd      <= '0;
      r_wb_rw   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      r_state <= r_state == S_RUN ? (w_req && !dmem.ready ? S_WAIT : S_RUN) : (w_done || !w_req ? S_RUN : S_WAIT);
      if (!o_mem_stall) begin
        r_rw      <= i_ex_valid & i_ex_reg_write;
        r_mr      <= i_ex_valid & i_ex_mem_read;
        r_mw      <= i_ex_valid & i_ex_mem_write;
        r_f3      <= i_ex_funct3;
        r_rd      <= i_ex_rd;
        r_alu     <= i_ex_alu_result;
        r_sd      <= i_ex_store_data;
        r_wb_rw   <= r_rw;
        r_wb_rd   <= r_rd;
        r_wb_data <= w_wb;
      end
    end
endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// tb_ex_mem_wb_pipe: directed vector table plus wait-state, back-to-back and reset sequences.
module tb_ex_mem_wb_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_rw = 1'b0, ex_mr = 1'b0, ex_mw = 1'b0;
  logic [2:0]  ex_f3 = '0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_alu = '0, ex_sd = '0;
  logic        mem_stall, misalign, em_rw, wb_rw;
  logic [4:0]  em_rd, wb_rd;
  logic [31:0] em_alu, wb_wd;
`ifdef DMEM_TIMEOUT_EN
  logic        fault;
`endif
  int total = 0;
  int bad = 0;
  ex_mem_wb_pipe_if dmem();
  ex_mem_wb_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .i_ex_valid(ex_valid), .i_ex_reg_write(ex_rw), .i_ex_mem_read(ex_mr), .i_ex_mem_write(ex_mw),
    .i_ex_funct3(ex_f3), .i_ex_rd(ex_rd), .i_ex_alu_result(ex_alu), .i_ex_store_data(ex_sd),
    .dmem(dmem), .o_mem_stall(mem_stall), .o_misalign(misalign),
`ifdef DMEM_TIMEOUT_EN
    .o_dmem_fault(fault),
`endif
    .o_ex_mem_reg_write(em_rw), .o_ex_mem_rd(em_rd), .o_ex_mem_alu_result(em_alu),
    .o_mem_wb_reg_write(wb_rw), .o_mem_wb_rd(wb_rd), .o_mem_wb_wdata(wb_wd)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic valid, rw, mr, mw;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [31:0] alu, sd, rdata;
    logic e_req, e_we;
    logic [3:0] e_be;
    logic [31:0] e_wdata;
    logic e_mis, e_wrw;
    logic [4:0] e_wrd;
    logic [31:0] e_wwd;
  } vec_t;
  vec_t vecs[13];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic drive(input logic v, rw, mr, mw, input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu, sd);
    ex_valid = v; ex_rw = rw; ex_mr = mr; ex_mw = mw; ex_f3 = f3; ex_rd = rd; ex_alu = alu; ex_sd = sd;
  endtask
  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 5'd0, 32'h0, 32'h0);
  endtask
  initial begin
    vecs[0]  = '{1,1,1,0,3'b010,5'd5,32'h100,32'h0,32'hDEADBEEF, 1,0,4'hF,32'h0,0, 1,5'd5,32'hDEADBEEF};
    vecs[1]  = '{1,1,1,0,3'b000,5'd7,32'h103,32'h0,32'h80123456, 1,0,4'h8,32'h0,0, 1,5'd7,32'hFFFFFF80};
    vecs[2]  = '{1,1,1,0,3'b100,5'd7,32'h103,32'h0,32'h80123456, 1,0,4'h8,32'h0,0, 1,5'd7,32'h00000080};
    vecs[3]  = '{1,0,0,1,3'b001,5'd0,32'h102,32'h1234,32'h0, 1,1,4'hC,32'h12341234,0, 0,5'd0,32'h102};
    vecs[4]  = '{1,1,1,0,3'b001,5'd8,32'h102,32'h0,32'hF00D1234, 1,0,4'hC,32'h0,0, 1,5'd8,32'hFFFFF00D};
    vecs[5]  = '{1,1,1,0,3'b101,5'd8,32'h100,32'h0,32'hF00D8001, 1,0,4'h3,32'h0,0, 1,5'd8,32'h00008001};
    vecs[6]  = '{1,0,0,1,3'b000,5'd0,32'h101,32'hAB,32'h0, 1,1,4'h2,32'hABABABAB,0, 0,5'd0,32'h101};
    vecs[7]  = '{1,0,0,1,3'b010,5'd0,32'h104,32'hCAFEF00D,32'h0, 1,1,4'hF,32'hCAFEF00D,0, 0,5'd0,32'h104};
    vecs[8]  = '{1,1,0,0,3'b000,5'd9,32'h55AA,32'h0,32'h0, 0,0,4'h0,32'h0,0, 1,5'd9,32'h55AA};
    vecs[9]  = '{1,1,1,0,3'b010,5'd10,32'h101,32'h0,32'hFFFFFFFF, 0,0,4'h0,32'h0,1, 1,5'd10,32'h0};
    vecs[10] = '{1,0,0,1,3'b010,5'd0,32'h102,32'h99,32'h0, 0,0,4'h0,32'h0,1, 0,5'd0,32'h102};
    vecs[11] = '{1,1,1,0,3'b001,5'd12,32'h103,32'h0,32'h12345678, 0,0,4'h0,32'h0,1, 1,5'd12,32'h0};
    vecs[12] = '{0,1,0,1,3'b010,5'd0,32'h0,32'h0,32'h0, 0,0,4'h0,32'h0,0, 0,5'd0,32'h0};
    dmem.rdata = '0;
    dmem.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'b0, dmem.req}, 32'h0);
    chk("rst_be_we_stall", {28'b0, dmem.be} | {31'b0, dmem.we} | {31'b0, mem_stall}, 32'h0);
    chk("rst_wb", {26'b0, wb_rw, wb_rd} | wb_wd, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].f3, vecs[i].rd, vecs[i].alu, vecs[i].sd);
      dmem.ready = 1'b0;
      @(negedge clk);
      bubble();
      dmem.rdata = vecs[i].rdata;
      dmem.ready = 1'b1;
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, dmem.req}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_we", i), {31'b0, dmem.we}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d_mis", i), {31'b0, misalign}, {31'b0, vecs[i].e_mis});
      chk($sformatf("v%0d_stall", i), {31'b0, mem_stall}, 32'h0);
      chk($sformatf("v%0d_em_rw", i), {31'b0, em_rw}, {31'b0, vecs[i].valid & vecs[i].rw});
      chk($sformatf("v%0d_em_alu", i), em_alu, vecs[i].alu);
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_addr", i), dmem.addr, {vecs[i].alu[31:2], 2'b00});
        chk($sformatf("v%0d_be", i), {28'b0, dmem.be}, {28'b0, vecs[i].e_be});
        chk($sformatf("v%0d_wdata", i), dmem.wdata, vecs[i].e_wdata);
      end
      @(negedge clk);
      chk($sformatf("v%0d_wb_rw", i), {31'b0, wb_rw}, {31'b0, vecs[i].e_wrw});
      chk($sformatf("v%0d_wb_rd", i), {27'b0, wb_rd}, {27'b0, vecs[i].e_wrd});
      chk($sformatf("v%0d_wb_wd", i), wb_wd, vecs[i].e_wwd);
    end
    // three wait states on a load, with an ALU op frozen behind it in EX
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd10, 32'h200, 32'h0);
    dmem.ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'd11, 32'h1111, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("ws%0d_stall", c), {31'b0, mem_stall}, 32'h1);
      chk($sformatf("ws%0d_req", c), {31'b0, dmem.req}, 32'h1);
      chk($sformatf("ws%0d_addr", c), dmem.addr, 32'h200);
      chk($sformatf("ws%0d_em_rd", c), {27'b0, em_rd}, 32'd10);
      chk($sformatf("ws%0d_wb", c), {26'b0, wb_rw, wb_rd}, 32'h0);
      @(negedge clk);
    end
    dmem.rdata = 32'h11223344;
    dmem.ready = 1'b1;
    #1;
    chk("ws_done_stall", {31'b0, mem_stall}, 32'h0);
    @(negedge clk);
    bubble();
    dmem.ready = 1'b0;
    chk("ws_wb_rd", {26'b0, wb_rw, wb_rd}, {26'b0, 1'b1, 5'd10});
    chk("ws_wb_wd", wb_wd, 32'h11223344);
    chk("ws_em_rd", {27'b0, em_rd}, 32'd11);
    @(negedge clk);
    chk("ws_alu_wb", wb_wd, 32'h1111);
    chk("ws_alu_rd", {27'b0, wb_rd}, 32'd11);
    // back-to-back loads with zero wait states
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd1, 32'h10, 32'h0);
    dmem.ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd2, 32'h14, 32'h0);
    dmem.rdata = 32'hAAAA0001;
    #1;
    chk("b2b_addr1", dmem.addr, 32'h10);
    chk("b2b_stall1", {31'b0, mem_stall}, 32'h0);
    @(negedge clk);
    bubble();
    dmem.rdata = 32'hBBBB0002;
    #1;
    chk("b2b_req2", {31'b0, dmem.req}, 32'h1);
    chk("b2b_addr2", dmem.addr, 32'h14);
    chk("b2b_wb1", wb_wd, 32'hAAAA0001);
    @(negedge clk);
    chk("b2b_wb2", wb_wd, 32'hBBBB0002);
    chk("b2b_wb2_rd", {27'b0, wb_rd}, 32'd2);
    // reset asserted while the access sits in S_WAIT
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd3, 32'h300, 32'h0);
    dmem.ready = 1'b0;
    @(negedge clk);
    bubble();
    @(negedge clk);
    chk("rw_stall_pre", {31'b0, mem_stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rw_req", {31'b0, dmem.req}, 32'h0);
    chk("rw_stall", {31'b0, mem_stall}, 32'h0);
    chk("rw_em", {26'b0, em_rw, em_rd} | em_alu, 32'h0);
    chk("rw_wb", {26'b0, wb_rw, wb_rd} | wb_wd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rw_after_req", {31'b0, dmem.req}, 32'h0);
`ifdef DMEM_TIMEOUT_EN
    begin
      int n;
      n = 0;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd4, 32'h400, 32'h0);
      dmem.rdata = 32'hFFFFFFFF;
      @(negedge clk);
      bubble();
      while (!fault && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("to_fault_seen", {31'b0, fault}, 32'h1);
      chk("to_cycles_ok", {31'b0, n >= 200 && n <= 202}, 32'h1);
      @(negedge clk);
      chk("to_wb", {26'b0, wb_rw, wb_rd}, {26'b0, 1'b1, 5'd4});
      chk("to_wb_wd", wb_wd, 32'h0);
      chk("to_stall", {31'b0, mem_stall}, 32'h0);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
